// File: rtl/chorus_sequencer.sv
// chorus_sequencer: per-sample LFO -> delay buffer -> mixer -> TX-FIFO sequencer with a one-deep pending slot.
// Define CHORUS_SEQ_WDOG_EN to add a per-wait-state watchdog that aborts a stalled sequence.
module chorus_sequencer #(
  parameter int PKT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 120
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [PKT_WIDTH-1:0] pktDry_i,
  input  logic                 pktDryChanged_i,
  input  logic [3:0]           freqSetting_i,
  input  logic [3:0]           scaleFactor_i,
  input  logic                 lfoValid_i,
  input  logic                 delayValid_i,
  input  logic                 mixValid_i,
  input  logic                 clrErr_i,
  output logic [PKT_WIDTH-1:0] pktDry_o,
  output logic [3:0]           freqSetting_o,
  output logic [3:0]           scaleFactor_o,
  output logic                 lfoStep_o,
  output logic                 delayWrite_o,
  output logic                 mixStart_o,
  output logic                 txWrite_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LFO_WAIT = 2'd1,
    DLY_WAIT = 2'd2,
    MIX_WAIT = 2'd3
  } state_t;

  state_t               state, nextState;
  logic                 pendValid, pendValidNext;
  logic [PKT_WIDTH-1:0] pendPkt, pendPktNext;
  logic [PKT_WIDTH-1:0] pktNext;
  logic [3:0]           freqNext, scaleNext;
  logic                 lfoStepNext, delayWriteNext, mixStartNext, txWriteNext;
  logic                 overrunNext, timeoutNext, busyNext;
  logic                 seqEnd, startNow, startFromPend, abortNow;

`ifdef CHORUS_SEQ_WDOG_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] waitCnt;
  logic            waitEntry;

  // Every wait-state entry coincides with exactly one request pulse
  assign waitEntry = lfoStepNext | delayWriteNext | mixStartNext;
  assign abortNow  = (state != IDLE) && (waitCnt == CntW'(TIMEOUT_CYCLES - 1));

  // Cycles spent in the current wait state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      waitCnt <= '0;
    end else if (waitEntry) begin
      waitCnt <= '0;
    end else if (state != IDLE) begin
      waitCnt <= waitCnt + CntW'(1);
    end else begin
      waitCnt <= waitCnt;
    end
  end
`else
  assign abortNow = 1'b0;
`endif

  // Next-state, pending-slot and output decode
  always_comb begin
    nextState      = state;
    pendValidNext  = pendValid;
    pendPktNext    = pendPkt;
    pktNext        = pktDry_o;
    freqNext       = freqSetting_o;
    scaleNext      = scaleFactor_o;
    lfoStepNext    = 1'b0;
    delayWriteNext = 1'b0;
    mixStartNext   = 1'b0;
    txWriteNext    = 1'b0;
    overrunNext    = overrun_o & ~clrErr_i;
    timeoutNext    = timeout_o & ~clrErr_i;
    seqEnd         = 1'b0;
    startNow       = 1'b0;
    startFromPend  = 1'b0;

    case (state)
      IDLE: begin
        startNow      = pendValid | pktDryChanged_i;
        startFromPend = pendValid;
      end
      LFO_WAIT: begin
        if (lfoValid_i) begin
          delayWriteNext = 1'b1;
          nextState      = DLY_WAIT;
        end else if (abortNow) begin
          timeoutNext = 1'b1;
          seqEnd      = 1'b1;
          nextState   = IDLE;
        end else begin
          nextState = LFO_WAIT;
        end
      end
      DLY_WAIT: begin
        if (delayValid_i) begin
          mixStartNext = 1'b1;
          nextState    = MIX_WAIT;
        end else if (abortNow) begin
          timeoutNext = 1'b1;
          seqEnd      = 1'b1;
          nextState   = IDLE;
        end else begin
          nextState = DLY_WAIT;
        end
      end
      MIX_WAIT: begin
        if (mixValid_i) begin
          txWriteNext = 1'b1;
          seqEnd      = 1'b1;
          nextState   = IDLE;
        end else if (abortNow) begin
          timeoutNext = 1'b1;
          seqEnd      = 1'b1;
          nextState   = IDLE;
        end else begin
          nextState = MIX_WAIT;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    // A finishing or aborted sequence hands straight over to the pending sample
    startNow      = startNow | (seqEnd & pendValid);
    startFromPend = startFromPend | (seqEnd & pendValid);

    if (startNow) begin
      pktNext       = startFromPend ? pendPkt : pktDry_i;
      freqNext      = freqSetting_i;
      scaleNext     = scaleFactor_i;
      lfoStepNext   = 1'b1;
      pendValidNext = 1'b0;
      nextState     = LFO_WAIT;
    end else begin
      lfoStepNext = 1'b0;
    end

    // Strobes not taken by an IDLE start use the slot; a slot full this cycle means drop
    if (pktDryChanged_i && ((state != IDLE) || pendValid)) begin
      if (pendValid) begin
        overrunNext = 1'b1;
      end else begin
        pendValidNext = 1'b1;
        pendPktNext   = pktDry_i;
      end
    end else begin
      pendPktNext = pendPktNext;
    end

    busyNext = (nextState != IDLE) | txWriteNext;
  end

  // State, pending slot and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      pendValid     <= 1'b0;
      pendPkt       <= '0;
      pktDry_o      <= '0;
      freqSetting_o <= 4'd0;
      scaleFactor_o <= 4'd0;
      lfoStep_o     <= 1'b0;
      delayWrite_o  <= 1'b0;
      mixStart_o    <= 1'b0;
      txWrite_o     <= 1'b0;
      busy_o        <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state         <= nextState;
      pendValid     <= pendValidNext;
      pendPkt       <= pendPktNext;
      pktDry_o      <= pktNext;
      freqSetting_o <= freqNext;
      scaleFactor_o <= scaleNext;
      lfoStep_o     <= lfoStepNext;
      delayWrite_o  <= delayWriteNext;
      mixStart_o    <= mixStartNext;
      txWrite_o     <= txWriteNext;
      busy_o        <= busyNext;
      overrun_o     <= overrunNext;
      timeout_o     <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_chorus_sequencer.sv
// tb_chorus_sequencer: directed stimulus, per-cycle comparison against a stage/queue model of the sequencer,
// plus hand-computed literal expectations at the key cycles.
module tb_chorus_sequencer;
  localparam int PW  = 16;
  localparam int TMO = 120;
`ifdef CHORUS_SEQ_WDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [PW-1:0] pktDry_i = '0;
  logic          pktDryChanged_i = 1'b0;
  logic [3:0]    freqSetting_i = 4'd3;
  logic [3:0]    scaleFactor_i = 4'd5;
  logic          lfoValid_i = 1'b0;
  logic          delayValid_i = 1'b0;
  logic          mixValid_i = 1'b0;
  logic          clrErr_i = 1'b0;
  logic [PW-1:0] pktDry_o;
  logic [3:0]    freqSetting_o, scaleFactor_o;
  logic          lfoStep_o, delayWrite_o, mixStart_o, txWrite_o, busy_o, overrun_o, timeout_o;

  chorus_sequencer #(.PKT_WIDTH(PW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .reset_i(reset_i), .pktDry_i(pktDry_i), .pktDryChanged_i(pktDryChanged_i),
    .freqSetting_i(freqSetting_i), .scaleFactor_i(scaleFactor_i), .lfoValid_i(lfoValid_i),
    .delayValid_i(delayValid_i), .mixValid_i(mixValid_i), .clrErr_i(clrErr_i),
    .pktDry_o(pktDry_o), .freqSetting_o(freqSetting_o), .scaleFactor_o(scaleFactor_o),
    .lfoStep_o(lfoStep_o), .delayWrite_o(delayWrite_o), .mixStart_o(mixStart_o),
    .txWrite_o(txWrite_o), .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stage 0 = idle, 1..3 = waiting for LFO / delay / mix; pending samples in a queue of depth 1
  int            stage = 0;
  int            waitCycles = 0;
  logic [PW-1:0] pend[$];
  logic [PW-1:0] ePkt = '0;
  logic [3:0]    eFreq = 4'd0, eScale = 4'd0;
  logic          eLfo = 1'b0, eDly = 1'b0, eMix = 1'b0, eTx = 1'b0;
  logic          eBusy = 1'b0, eOvr = 1'b0, eTmo = 1'b0;

  task automatic modelStep();
    bit            endSeq, startIt, strobeUsed, slotFull, stageValid;
    logic [PW-1:0] startPkt;
    endSeq = 1'b0; startIt = 1'b0; strobeUsed = 1'b0; startPkt = '0;
    slotFull = (pend.size() != 0);
    eLfo = 1'b0; eDly = 1'b0; eMix = 1'b0; eTx = 1'b0;
    if (reset_i) begin
      stage = 0; waitCycles = 0; pend.delete();
      ePkt = '0; eFreq = 4'd0; eScale = 4'd0; eBusy = 1'b0; eOvr = 1'b0; eTmo = 1'b0;
      return;
    end
    if (clrErr_i) begin
      eOvr = 1'b0; eTmo = 1'b0;
    end
    stageValid = (stage == 1 && lfoValid_i) || (stage == 2 && delayValid_i) || (stage == 3 && mixValid_i);
    if (stage == 0) begin
      if (pend.size() != 0) begin
        startIt = 1'b1; startPkt = pend.pop_front();
      end else if (pktDryChanged_i) begin
        startIt = 1'b1; startPkt = pktDry_i; strobeUsed = 1'b1;
      end
    end else begin
      waitCycles++;
      if (stageValid) begin
        if (stage == 1) eDly = 1'b1;
        if (stage == 2) eMix = 1'b1;
        if (stage == 3) begin
          eTx = 1'b1; endSeq = 1'b1;
        end else begin
          stage++; waitCycles = 0;
        end
      end else if (WdogOn && waitCycles >= TMO) begin
        eTmo = 1'b1; endSeq = 1'b1;
      end
    end
    if (endSeq) begin
      stage = 0;
      if (pend.size() != 0) begin
        startIt = 1'b1; startPkt = pend.pop_front();
      end
    end
    if (pktDryChanged_i && !strobeUsed) begin
      if (slotFull) eOvr = 1'b1;
      else pend.push_back(pktDry_i);
    end
    if (startIt) begin
      ePkt = startPkt; eFreq = freqSetting_i; eScale = scaleFactor_i;
      eLfo = 1'b1; stage = 1; waitCycles = 0;
    end
    eBusy = (stage != 0) || eTx;
  endtask

  // Compare DUT against the model mid-cycle, then advance the model with the inputs about to be sampled
  initial begin
    forever begin
      @(negedge clk);
      chk("pktDry_o", 32'(pktDry_o), 32'(ePkt));
      chk("freqSetting_o", 32'(freqSetting_o), 32'(eFreq));
      chk("scaleFactor_o", 32'(scaleFactor_o), 32'(eScale));
      chk("lfoStep_o", 32'(lfoStep_o), 32'(eLfo));
      chk("delayWrite_o", 32'(delayWrite_o), 32'(eDly));
      chk("mixStart_o", 32'(mixStart_o), 32'(eMix));
      chk("txWrite_o", 32'(txWrite_o), 32'(eTx));
      chk("busy_o", 32'(busy_o), 32'(eBusy));
      chk("overrun_o", 32'(overrun_o), 32'(eOvr));
      chk("timeout_o", 32'(timeout_o), 32'(eTmo));
      modelStep();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [PW-1:0] s);
    pktDry_i = s; pktDryChanged_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0;
  endtask

  // Finish a sequence from LFO_WAIT with same-cycle responders, ending one cycle after txWrite_o
  task automatic fastFinish();
    lfoValid_i = 1'b1; tick(); lfoValid_i = 1'b0;
    delayValid_i = 1'b1; tick(); delayValid_i = 1'b0;
    mixValid_i = 1'b1; tick(); mixValid_i = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset pkt", 32'(pktDry_o), 32'd0);
    chk("reset freq", 32'(freqSetting_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // Single sample, responders one cycle after each request
    strobe(16'h1234);
    chk("single N+1 lfoStep", 32'(lfoStep_o), 32'd1);
    chk("single N+1 busy", 32'(busy_o), 32'd1);
    chk("single N+1 pkt", 32'(pktDry_o), 32'h1234);
    chk("single N+1 freq", 32'(freqSetting_o), 32'd3);
    tick(); lfoValid_i = 1'b1; tick(); lfoValid_i = 1'b0;
    chk("single N+3 delayWrite", 32'(delayWrite_o), 32'd1);
    tick(); delayValid_i = 1'b1; tick(); delayValid_i = 1'b0;
    chk("single N+5 mixStart", 32'(mixStart_o), 32'd1);
    tick(); mixValid_i = 1'b1; tick(); mixValid_i = 1'b0;
    chk("single N+7 txWrite", 32'(txWrite_o), 32'd1);
    chk("single N+7 pkt", 32'(pktDry_o), 32'h1234);
    chk("single N+7 busy", 32'(busy_o), 32'd1);
    tick();
    chk("single N+8 busy", 32'(busy_o), 32'd0);

    // Settings change while in DLY_WAIT
    strobe(16'hAAAA);
    lfoValid_i = 1'b1; tick(); lfoValid_i = 1'b0;
    freqSetting_i = 4'd9;
    tick(); delayValid_i = 1'b1; tick(); delayValid_i = 1'b0;
    chk("settings held", 32'(freqSetting_o), 32'd3);
    mixValid_i = 1'b1; tick(); mixValid_i = 1'b0;
    chk("settings held at tx", 32'(freqSetting_o), 32'd3);
    tick();
    strobe(16'h5555);
    chk("settings next sample", 32'(freqSetting_o), 32'd9);
    fastFinish();

    // Overrun: A runs, B pending, C dropped
    strobe(16'h000A);
    strobe(16'h000B);
    strobe(16'h000C);
    chk("overrun set", 32'(overrun_o), 32'd1);
    chk("overrun pkt A kept", 32'(pktDry_o), 32'h000A);
    lfoValid_i = 1'b1; tick(); lfoValid_i = 1'b0;
    delayValid_i = 1'b1; tick(); delayValid_i = 1'b0;
    mixValid_i = 1'b1; tick(); mixValid_i = 1'b0;
    chk("b2b txWrite", 32'(txWrite_o), 32'd1);
    chk("b2b lfoStep", 32'(lfoStep_o), 32'd1);
    chk("b2b pkt B", 32'(pktDry_o), 32'h000B);
    chk("b2b busy", 32'(busy_o), 32'd1);
    clrErr_i = 1'b1; tick(); clrErr_i = 1'b0;
    chk("overrun cleared", 32'(overrun_o), 32'd0);
    fastFinish();

    // Strobe together with mixValid_i, slot empty
    strobe(16'h0D0D);
    lfoValid_i = 1'b1; tick(); lfoValid_i = 1'b0;
    delayValid_i = 1'b1; tick(); delayValid_i = 1'b0;
    mixValid_i = 1'b1; strobe(16'h0E0E); mixValid_i = 1'b0;
    chk("simul txWrite", 32'(txWrite_o), 32'd1);
    chk("simul no lfoStep yet", 32'(lfoStep_o), 32'd0);
    tick();
    chk("simul lfoStep", 32'(lfoStep_o), 32'd1);
    chk("simul pkt E", 32'(pktDry_o), 32'h0E0E);
    chk("simul no overrun", 32'(overrun_o), 32'd0);
    fastFinish();

    // Delay stage never answers
    strobe(16'h0F0F);
    lfoValid_i = 1'b1; tick(); lfoValid_i = 1'b0;
    repeat (130) tick();
    chk("stall no mixStart", 32'(mixStart_o), 32'd0);
`ifdef CHORUS_SEQ_WDOG_EN
    chk("wdog timeout", 32'(timeout_o), 32'd1);
    chk("wdog idle", 32'(busy_o), 32'd0);
`else
    chk("nowdog timeout", 32'(timeout_o), 32'd0);
    chk("nowdog still busy", 32'(busy_o), 32'd1);
`endif
    reset_i = 1'b1; tick(); reset_i = 1'b0; tick();

    // Reset in MIX_WAIT with a pending sample
    strobe(16'h1111);
    pktDry_i = 16'h2222; pktDryChanged_i = 1'b1; lfoValid_i = 1'b1;
    tick();
    pktDryChanged_i = 1'b0; lfoValid_i = 1'b0;
    delayValid_i = 1'b1; tick(); delayValid_i = 1'b0;
    chk("pre-reset mixStart", 32'(mixStart_o), 32'd1);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    chk("mid reset busy", 32'(busy_o), 32'd0);
    chk("mid reset pkt", 32'(pktDry_o), 32'd0);
    chk("mid reset lfoStep", 32'(lfoStep_o), 32'd0);
    chk("mid reset freq", 32'(freqSetting_o), 32'd0);
    mixValid_i = 1'b1; tick(); mixValid_i = 1'b0;
    chk("post reset no txWrite", 32'(txWrite_o), 32'd0);
    repeat (4) tick();
    chk("post reset idle", 32'(busy_o), 32'd0);
    chk("post reset no lfoStep", 32'(lfoStep_o), 32'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
